gpio_in_resp: RTL

- Memory-mapped GPIO input responder on the LSU data bus; the read-side counterpart to the LSU's gpioA/gpioB output registers.
- Synchronises NUM_PINS external input pins and detects rising/falling edges into sticky W1C status bits.
- Drives a level interrupt and returns registered read data with the same 1-cycle latency as the RAM.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/gpio_sync.sv | 76 +++++++
 rtl/gpio_in_resp.sv | 113 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: GPIO register map and load/store data-type encodings.
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 12;

    // GPIO output registers live just below the input responder's window.
    localparam logic [LSU_ADDR_W-1:0] ADDR_GPIO_A    = 12'hEF0;
    localparam logic [LSU_ADDR_W-1:0] ADDR_GPIO_B    = 12'hEF4;
    localparam logic [LSU_ADDR_W-1:0] ADDR_GPIO_IN   = 12'hEF8;
    localparam logic [LSU_ADDR_W-1:0] ADDR_GPIO_STAT = 12'hEFC;
    localparam logic [LSU_ADDR_W-1:0] ADDR_GPIO_RISE = 12'hF00;
    localparam logic [LSU_ADDR_W-1:0] ADDR_GPIO_FALL = 12'hF04;

    typedef enum logic [2:0] {
        BYTE               = 3'd0,
        HALF_WORD          = 3'd1,
        WORD               = 3'd2,
        BYTE_UNSIGNED      = 3'd3,
        HALF_WORD_UNSIGNED = 3'd4
    } dtype_e;

endpackage

// File: rtl/gpio_sync.sv
// Per-pin two-flop synchroniser with an optional debounce filter.
// Define GPIO_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter after the synchroniser.
module gpio_sync
    import lsu_pkg::*;
#(
    parameter int unsigned NUM_PINS        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_PINS-1:0] pins_in,
    output logic [NUM_PINS-1:0] level_out
);

    logic [NUM_PINS-1:0] meta_q, meta_d;
    logic [NUM_PINS-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = pins_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0]    cnt_q [NUM_PINS];
    logic [CNT_W-1:0]    cnt_d [NUM_PINS];
    logic [NUM_PINS-1:0] filt_q, filt_d;

    // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_PINS; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt_q[i] <= '0;
            end
            filt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign level_out = filt_q;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = |DEBOUNCE_CYCLES;

    assign level_out = sync_q;
`endif

endmodule

// File: rtl/gpio_in_resp.sv
// Memory-mapped GPIO input responder: pin level, sticky W1C edge status, edge masks, level IRQ.
// Define GPIO_DEBOUNCE_EN to filter pins through a DEBOUNCE_CYCLES debounce before edge detection.
module gpio_in_resp
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDRESS_SPACE   = 4096,
    parameter int unsigned NUM_PINS        = 16,
    parameter logic [$clog2(ADDRESS_SPACE)-1:0] GPIO_IN_ADDR   = ADDR_GPIO_IN,
    parameter logic [$clog2(ADDRESS_SPACE)-1:0] GPIO_STAT_ADDR = ADDR_GPIO_STAT,
    parameter logic [$clog2(ADDRESS_SPACE)-1:0] GPIO_RISE_ADDR = ADDR_GPIO_RISE,
    parameter logic [$clog2(ADDRESS_SPACE)-1:0] GPIO_FALL_ADDR = ADDR_GPIO_FALL,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [$clog2(ADDRESS_SPACE)-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             WE_in,
    input  logic [NUM_PINS-1:0]              pins_in,
    output logic                             hit_out,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             irq_out
);

    logic [NUM_PINS-1:0]   level;
    logic [NUM_PINS-1:0]   prev_q, prev_d;
    logic [NUM_PINS-1:0]   status_q, status_d;
    logic [NUM_PINS-1:0]   rise_mask_q, rise_mask_d;
    logic [NUM_PINS-1:0]   fall_mask_q, fall_mask_d;
    logic [1:0]            arm_q, arm_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  irq_q, irq_d;

    logic                  sel_in, sel_stat, sel_rise, sel_fall;
    logic                  armed;
    logic [NUM_PINS-1:0]   wr_val, w1c, rise, fall;
    logic                  unused_data;

    assign unused_data = ^data_in;

    gpio_sync #(
        .NUM_PINS        (NUM_PINS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .pins_in   (pins_in),
        .level_out (level)
    );

    always_comb begin
        sel_in   = (addr_in == GPIO_IN_ADDR);
        sel_stat = (addr_in == GPIO_STAT_ADDR);
        sel_rise = (addr_in == GPIO_RISE_ADDR);
        sel_fall = (addr_in == GPIO_FALL_ADDR);
        hit_out  = sel_in | sel_stat | sel_rise | sel_fall;
    end

    // Edges stay suppressed until the synchroniser has flushed its reset zeros.
    always_comb begin
        armed  = (arm_q == 2'd3);
        arm_d  = armed ? arm_q : arm_q + 2'd1;
        prev_d = level;
        rise   = armed ? (level & ~prev_q & rise_mask_q) : '0;
        fall   = armed ? (~level & prev_q & fall_mask_q) : '0;

        wr_val      = data_in[NUM_PINS-1:0];
        w1c         = (WE_in && sel_stat) ? wr_val : '0;
        status_d    = (status_q & ~w1c) | rise | fall;
        rise_mask_d = (WE_in && sel_rise) ? wr_val : rise_mask_q;
        fall_mask_d = (WE_in && sel_fall) ? wr_val : fall_mask_q;
        irq_d       = |status_q;
    end

    // Read mux samples the current registers, so a same-cycle write returns the old value.
    always_comb begin
        data_out_d = '0;
        if (sel_in) begin
            data_out_d[NUM_PINS-1:0] = level;
        end else if (sel_stat) begin
            data_out_d[NUM_PINS-1:0] = status_q;
        end else if (sel_rise) begin
            data_out_d[NUM_PINS-1:0] = rise_mask_q;
        end else if (sel_fall) begin
            data_out_d[NUM_PINS-1:0] = fall_mask_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= '0;
            status_q    <= '0;
            rise_mask_q <= '0;
            fall_mask_q <= '0;
            arm_q       <= '0;
            data_out_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            status_q    <= status_d;
            rise_mask_q <= rise_mask_d;
            fall_mask_q <= fall_mask_d;
            arm_q       <= arm_d;
            data_out_q  <= data_out_d;
            irq_q       <= irq_d;
        end
    end

    assign data_out = data_out_q;
    assign irq_out  = irq_q;

endmodule
